// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: PC width, BTB counter encoding and saturation helpers.
// The fetch_unit optional statistics block is enabled with FETCH_BTB_STATS_EN.
package fetch_unit_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bctr_e;

  function automatic bctr_e ctr_inc(input bctr_e c);
    return (c == ST) ? ST : bctr_e'(c + 2'd1);
  endfunction

  function automatic bctr_e ctr_dec(input bctr_e c);
    return (c == SNT) ? SNT : bctr_e'(c - 2'd1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup port plus one training write port applied at the clock edge.
module fetch_btb
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic            taken,
  output logic [PC_W-1:0] target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = PC_W - IDX;

  logic            valid_q [ENTRIES];
  logic [TW-1:0]   tag_q   [ENTRIES];
  logic [PC_W-1:0] tgt_q   [ENTRIES];
  bctr_e           ctr_q   [ENTRIES];

  logic [IDX-1:0] l_idx, u_idx;
  logic [TW-1:0]  l_tag, u_tag;
  logic           u_hit;

  assign l_idx = lookup_pc[IDX-1:0];
  assign l_tag = lookup_pc[PC_W-1:IDX];
  assign u_idx = upd_pc[IDX-1:0];
  assign u_tag = upd_pc[PC_W-1:IDX];

  always_comb begin
    hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    taken  = (ctr_q[l_idx] == WT) || (ctr_q[l_idx] == ST);
    target = tgt_q[l_idx];
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  end

  // Lookup is read from the registered arrays, so a same-cycle update to the
  // indexed entry is only visible from the next cycle on.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i[IDX-1:0]] <= 1'b0;
        ctr_q[i[IDX-1:0]]   <= SNT;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr_q[u_idx] <= ctr_inc(ctr_q[u_idx]);
          tgt_q[u_idx] <= upd_target;
        end else begin
          ctr_q[u_idx] <= ctr_dec(ctr_q[u_idx]);
        end
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target;
        ctr_q[u_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-based next-PC prediction and F/D latch control.
// Define FETCH_BTB_STATS_EN to add the stat_lookups/stat_hits/stat_redirects counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [PC_W-1:0] update_pc,
  input  logic            update_taken,
  input  logic [PC_W-1:0] update_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_data,
  output logic            fd_en,
  output logic            fd_clr,
  output logic [PC_W-1:0] tg_out,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1_out,
  output logic [PC_W-1:0] ir_out
`ifdef FETCH_BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_redirects
`endif
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pc_plus1;
  logic            btb_hit;
  logic            btb_taken;
  logic [PC_W-1:0] btb_target;
  logic            pred_taken;

  // Reset is synchronous, yet the outputs must show RESET_PC while it is held,
  // so the current PC is overridden combinationally rather than waiting an edge.
  always_comb begin
    pc_cur     = reset ? RESET_PC : pc_q;
    pc_plus1   = pc_cur + 32'd1;
    pred_taken = ~reset & btb_hit & btb_taken;
    tg_out     = pred_taken ? btb_target : pc_plus1;
  end

  fetch_btb #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lookup_pc (pc_cur),
    .hit       (btb_hit),
    .taken     (btb_taken),
    .target    (btb_target),
    .upd_valid (update_valid),
    .upd_pc    (update_pc),
    .upd_taken (update_taken),
    .upd_target(update_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (!stall) begin
      pc_q <= tg_out;
    end
  end

  assign imem_addr    = pc_cur;
  assign pc_out       = pc_cur;
  assign pc_plus1_out = pc_plus1;
  assign ir_out       = imem_data;
  assign fd_en        = ~stall | redirect_valid | reset;
  assign fd_clr       = redirect_valid | reset;

`ifdef FETCH_BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups   <= '0;
      stat_hits      <= '0;
      stat_redirects <= '0;
    end else begin
      if (!stall) begin
        stat_lookups <= sat_inc32(stat_lookups);
        if (pred_taken) begin
          stat_hits <= sat_inc32(stat_hits);
        end
      end
      if (redirect_valid) begin
        stat_redirects <= sat_inc32(stat_redirects);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a per-cycle reference model of PC flow and BTB training.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          NENT   = 16;
  localparam logic [31:0] IMEM_K = 32'hA5A5_0F0F;

  logic        clk;
  logic        reset, stall, redirect_valid, update_valid, update_taken;
  logic [31:0] redirect_pc, update_pc, update_target;
  logic [31:0] imem_addr, imem_data, tg_out, pc_out, pc_plus1_out, ir_out;
  logic        fd_en, fd_clr;
`ifdef FETCH_BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_redirects;
`endif

  int checks = 0;
  int failures = 0;

  assign imem_data = imem_addr ^ IMEM_K;

  fetch_unit #(
    .BTB_ENTRIES(NENT),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .fd_en         (fd_en),
    .fd_clr        (fd_clr),
    .tg_out        (tg_out),
    .pc_out        (pc_out),
    .pc_plus1_out  (pc_plus1_out),
    .ir_out        (ir_out)
`ifdef FETCH_BTB_STATS_EN
    ,
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_redirects(stat_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each entry remembers the full branch PC it was trained with.
  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        m_btb [NENT];
  logic [31:0] m_pc;
  bit          m_known = 0;
  int          m_lookups = 0, m_hits = 0, m_redirects = 0;

  function automatic logic [31:0] m_pred(input logic [31:0] p, output bit tk);
    int i;
    i  = int'(p % NENT);
    tk = m_btb[i].v && (m_btb[i].pc == p) && (m_btb[i].ctr >= 2);
    return tk ? m_btb[i].tgt : p + 32'd1;
  endfunction

  initial begin
    for (int i = 0; i < NENT; i++) m_btb[i] = '{0, 32'h0, 32'h0, 0};
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pc = RST_PC;
        for (int i = 0; i < NENT; i++) begin
          m_btb[i].v   = 0;
          m_btb[i].ctr = 0;
        end
        m_lookups = 0; m_hits = 0; m_redirects = 0;
        m_known = 1;
      end else if (m_known) begin
        bit          tk;
        logic [31:0] nxt;
        int          i;
        nxt = m_pred(m_pc, tk);
        if (!stall) begin
          m_lookups++;
          if (tk) m_hits++;
        end
        if (redirect_valid) m_redirects++;
        if (redirect_valid) m_pc = redirect_pc;
        else if (!stall) m_pc = nxt;
        if (update_valid) begin
          i = int'(update_pc % NENT);
          if (m_btb[i].v && m_btb[i].pc == update_pc) begin
            if (update_taken) begin
              m_btb[i].ctr = (m_btb[i].ctr == 3) ? 3 : m_btb[i].ctr + 1;
              m_btb[i].tgt = update_target;
            end else begin
              m_btb[i].ctr = (m_btb[i].ctr == 0) ? 0 : m_btb[i].ctr - 1;
            end
          end else if (update_taken) begin
            m_btb[i] = '{1, update_pc, update_target, 2};
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset || m_known) begin
      bit          tk;
      logic [31:0] epc, etg;
      epc = reset ? RST_PC : m_pc;
      etg = reset ? RST_PC + 32'd1 : m_pred(m_pc, tk);
      chk("model.pc_out", pc_out, epc);
      chk("model.imem_addr", imem_addr, epc);
      chk("model.pc_plus1", pc_plus1_out, epc + 32'd1);
      chk("model.tg_out", tg_out, etg);
      chk("model.ir_out", ir_out, epc ^ IMEM_K);
      chk("model.fd_en", {31'b0, fd_en}, {31'b0, (~stall | redirect_valid | reset)});
      chk("model.fd_clr", {31'b0, fd_clr}, {31'b0, (redirect_valid | reset)});
`ifdef FETCH_BTB_STATS_EN
      if (!reset) begin
        chk("model.stat_lookups", stat_lookups, 32'(m_lookups));
        chk("model.stat_hits", stat_hits, 32'(m_hits));
        chk("model.stat_redirects", stat_redirects, 32'(m_redirects));
      end
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] p, input logic t, input logic [31:0] tgt);
    update_valid  = 1'b1;
    update_pc     = p;
    update_taken  = t;
    update_target = tgt;
    tick();
    update_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;

    settle();
    chk("rst.pc", pc_out, 32'h100);
    chk("rst.tg", tg_out, 32'h101);
    chk("rst.clr", {31'b0, fd_clr}, 32'd1);
    chk("rst.en", {31'b0, fd_en}, 32'd1);
    tick();
    reset = 1'b0;

    settle(); chk("run.pc0", pc_out, 32'h100);
    chk("run.clr0", {31'b0, fd_clr}, 32'd0);
    tick(); settle(); chk("run.pc1", pc_out, 32'h101);
    tick(); settle(); chk("run.pc2", pc_out, 32'h102);

    stall = 1'b1;
    settle(); chk("stall.pc", pc_out, 32'h102);
    chk("stall.en", {31'b0, fd_en}, 32'd0);
    tick(); settle(); chk("stall.pc_hold", pc_out, 32'h102);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    settle();
    chk("flush.clr", {31'b0, fd_clr}, 32'd1);
    chk("flush.en", {31'b0, fd_en}, 32'd1);
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    settle(); chk("flush.pc", pc_out, 32'h300);

    train(32'h104, 1'b1, 32'h200);
    redirect_to(32'h104);
    settle(); chk("alloc.tg", tg_out, 32'h200);
    tick(); settle(); chk("alloc.pc", pc_out, 32'h200);

    train(32'h104, 1'b0, 32'h0);
    train(32'h104, 1'b0, 32'h0);
    redirect_to(32'h104);
    settle(); chk("nt2.tg", tg_out, 32'h105);

    train(32'h104, 1'b1, 32'h250);
    redirect_to(32'h104);
    settle(); chk("wnt.tg", tg_out, 32'h105);
    train(32'h104, 1'b1, 32'h250);
    redirect_to(32'h104);
    settle(); chk("retarget.tg", tg_out, 32'h250);

    train(32'h004, 1'b1, 32'h050);
    train(32'h014, 1'b1, 32'h060);
    redirect_to(32'h004);
    settle(); chk("alias.tg004", tg_out, 32'h005);
    redirect_to(32'h014);
    settle(); chk("alias.tg014", tg_out, 32'h060);

    train(32'h014, 1'b0, 32'h0);
    settle(); chk("sameidx.pc", pc_out, 32'h060);
    redirect_to(32'h014);
    settle(); chk("sameidx.tg", tg_out, 32'h015);

    train(32'h020, 1'b1, 32'h080);
    redirect_to(32'h020);
    settle(); chk("pre_rst.tg", tg_out, 32'h080);

    redirect_to(32'hFFFF_FFFF);
    settle();
    chk("wrap.plus1", pc_plus1_out, 32'h0);
    chk("wrap.tg", tg_out, 32'h0);
    tick(); settle(); chk("wrap.pc", pc_out, 32'h0);

    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    settle();
    chk("rstredir.pc", pc_out, 32'h100);
    chk("rstredir.tg", tg_out, 32'h101);
    tick();
    reset = 1'b0; redirect_valid = 1'b0;
    settle(); chk("rstredir.pc_after", pc_out, 32'h100);
    redirect_to(32'h020);
    settle(); chk("rst_clears.tg", tg_out, 32'h021);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    train(32'h101, 1'b1, 32'h100);
    settle(); chk("loop.pc", pc_out, 32'h101);
    chk("loop.tg", tg_out, 32'h100);
    tick(); tick(); tick();
    redirect_to(32'h300);
    stall = 1'b1;
    settle();
    chk("loop.pc_end", pc_out, 32'h300);
`ifdef FETCH_BTB_STATS_EN
    chk("stats.lookups", stat_lookups, 32'd5);
    chk("stats.hits", stat_hits, 32'd2);
    chk("stats.redirects", stat_redirects, 32'd1);
`endif
    tick();
    stall = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
